// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter for 16 requesters driving a 4-to-16 demux tree with break-before-make handover.
// Optional forced-revoke hold timer is built when ARB_TIMEOUT_EN is defined.
module demux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        rel,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        tmo
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [3:0]  sel_reg, sel_next;
  logic        tmo_reg, tmo_next;
  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic [3:0]  pick_off;
  logic [3:0]  pick_idx;
  logic [15:0] sel_dec;
  logic [15:0] others;
  logic        owner_req;
  logic        release_now;
  logic        timeout_now;

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD out of range 1..255");
    end
  endgenerate

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  assign req_dbl = {req, req} >> ptr_reg;
  assign req_rot = req_dbl[15:0];

  always_comb begin
    pick_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 4'(i);
    end
  end

  assign pick_idx = ptr_reg + pick_off;

  // Two-level decode: sel[3:2] picks the first-level demux, sel[1:0] the leaf.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
      localparam logic [3:0] IDX = 4'(gi);
      assign sel_dec[gi] = (sel_reg[3:2] == IDX[3:2]) && (sel_reg[1:0] == IDX[1:0]);
    end
  endgenerate

  assign owner_req   = req[sel_reg];
  assign others      = req & ~sel_dec;
  assign release_now = rel | ~owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_reg, hold_next;

  assign timeout_now = (hold_reg == HOLD_LAST) && (|others) && !release_now;

  // Saturates at the last cycle so a late-arriving contender revokes at once.
  always_comb begin
    hold_next = 8'd0;
    if (state_reg == GRANT && state_next == GRANT) begin
      hold_next = (hold_reg == HOLD_LAST) ? hold_reg : hold_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_reg <= 8'd0;
    else     hold_reg <= hold_next;
  end
`else
  assign timeout_now = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    tmo_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          sel_next   = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now || timeout_now) begin
          state_next = IDLE;
          ptr_next   = sel_reg + 4'd1;
          tmo_next   = timeout_now;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 4'd0;
      sel_reg   <= 4'd0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign sel  = sel_reg;
  assign busy = (state_reg == GRANT);
  assign gnt  = busy ? sel_dec : 16'd0;
  assign tmo  = tmo_reg;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Table-driven, scoreboard-checked bench for demux_rr_arbiter (MAX_HOLD=4).
module tb_demux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic        busy;
    logic [3:0]  sel;
    logic        tmo;
  } vec_t;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        tmo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  demux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .rel  (rel),
    .sel  (sel),
    .gnt  (gnt),
    .busy (busy),
    .tmo  (tmo)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [15:0] rq, input logic rl,
                     input logic b, input logic [3:0] s, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.rel = rl; v.busy = b; v.sel = s; v.tmo = t;
    vecs.push_back(v);
  endtask

  task automatic check(input int idx, input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    logic [15:0] one;
    @(negedge clk);
    rst = v.rst;
    req = v.req;
    rel = v.rel;
    one = 16'd1;
    e.gnt  = v.busy ? (one << v.sel) : 16'd0;
    e.sel  = v.sel;
    e.busy = v.busy;
    e.tmo  = v.tmo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(idx, "gnt", gnt, e.gnt);
    check(idx, "sel", {12'd0, sel}, {12'd0, e.sel});
    check(idx, "busy", {15'd0, busy}, {15'd0, e.busy});
    check(idx, "tmo", {15'd0, tmo}, {15'd0, e.tmo});
    check(idx, "gnt_onehot", {15'd0, ($countones(gnt) <= 1)}, 16'd1);
    $display("vec %0d rst=%b req=%h rel=%b -> gnt=%h sel=%0d busy=%b tmo=%b",
             idx, v.rst, v.req, v.rel, gnt, sel, busy, tmo);
  endtask

  initial begin
    rst = 1'b1;
    req = 16'd0;
    rel = 1'b0;

    // Reset, single request, release, ptr advanced to 1
    add(1, 16'h0000, 0, 0, 0, 0);
    add(0, 16'h0001, 0, 1, 0, 0);
    add(0, 16'h0001, 1, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0);
    add(0, 16'h0003, 0, 1, 1, 0);
    add(0, 16'h0003, 1, 0, 1, 0);
    add(0, 16'h0000, 0, 0, 1, 0);
    // All requesting: grants 0..15 with an idle cycle between each
    add(1, 16'hFFFF, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      add(0, 16'hFFFF, 0, 1, 4'(k), 0);
      add(0, 16'hFFFF, 1, 0, 4'(k), 0);
    end
    // Wrap: after releasing 15, 0 wins over 15
    add(0, 16'h8001, 0, 1, 0, 0);
    add(0, 16'h8001, 1, 0, 0, 0);
    // Owner withdrawal, then 6 first from ptr=6
    add(0, 16'h0020, 0, 1, 5, 0);
    add(0, 16'h0040, 0, 0, 5, 0);
    add(0, 16'h0060, 0, 1, 6, 0);
    add(0, 16'h00E0, 0, 1, 6, 0);
    add(0, 16'h00E0, 1, 0, 6, 0);
    // Scan from 7 wraps past 15 to reach 5; rel with withdrawal is one release
    add(0, 16'h0060, 0, 1, 5, 0);
    add(0, 16'h0000, 1, 0, 5, 0);
    // Reset mid-grant of 7, then arbitration restarts from ptr=0
    add(0, 16'h0080, 0, 1, 7, 0);
    add(1, 16'h0081, 0, 0, 0, 0);
    add(0, 16'h0081, 0, 1, 0, 0);
    add(0, 16'h0081, 1, 0, 0, 0);
    add(1, 16'h0000, 0, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) add(0, 16'h0003, 0, 1, 0, 0);
    add(0, 16'h0003, 0, 0, 0, 1);
    add(0, 16'h0003, 0, 1, 1, 0);
    add(0, 16'h0001, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) add(0, 16'h0001, 0, 1, 0, 0);
    add(0, 16'h0003, 0, 0, 0, 1);
    add(0, 16'h0000, 0, 0, 0, 0);
`else
    for (int k = 0; k < 10; k++) add(0, 16'h0003, 0, 1, 0, 0);
    add(0, 16'h0003, 1, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_rr_arbiter.md
# demux_rr_arbiter

Round-robin arbiter that shares a single demultiplexed resource among 16 requesters. It drives the 4-bit select of the 4-to-16 decoder tree, which is built from two levels of 1-to-4 demuxes, and it also produces the matching one-hot grant vector. Grants are held until the owner releases. Every handover passes through one idle cycle so that no two decoded enables are ever active together (break-before-make).

## Interface
- `MAX_HOLD`, default 8: maximum cycles one owner may hold the grant while others wait. Used only under `ARB_TIMEOUT_EN`. Legal range 1–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  16  request vector; `req[i]` high while requester i wants the resource.
- `rel`  in  1  release strobe from the current owner; sampled only in GRANT.
- `sel`  out  4  index of the granted requester, in decoder order: `sel[3]`=s0, `sel[2]`=s1, `sel[1]`=s2, `sel[0]`=s3.
- `gnt`  out  16  one-hot grant, equal to `decode(sel)` in GRANT, all zero otherwise.
- `busy`  out  1  high in GRANT.
- `tmo`  out  1  one-cycle pulse when a grant is forcibly revoked. Constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- State machine with two registered states:
  - **IDLE**: `gnt`=0, `busy`=0.
  - **GRANT**: `gnt`=one-hot(`sel`), `busy`=1.
- Rotating priority pointer `ptr` (4 bits) marks the highest-priority requester for the next arbitration.
- IDLE, `req`≠0:
  - Pick the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … mod 16. The scan wraps 15→0.
  - Register i into `sel` and enter GRANT.
- IDLE, `req`=0: stay in IDLE; `sel` holds its last value; `rel` is ignored.
- GRANT exits to IDLE on any of:
  - `rel`=1;
  - `req[sel]`=0 (owner withdrew, treated as a release);
  - timeout (see Configuration).
- On GRANT exit, `ptr` ← `sel`+1 mod 16. Owner 15 therefore wraps `ptr` to 0.
- `rel` together with `req[sel]`=0 in the same cycle counts as a single release.
- Requests that arrive or drop while another requester holds the grant do not disturb the grant. They are considered at the next IDLE cycle.
- `gnt` is always one-hot or zero. Its population count is never greater than 1.

## Timing
- Reset values: state=IDLE, `ptr`=0, `sel`=0, `gnt`=0, `busy`=0, `tmo`=0, hold counter=0.
- Reset asserted mid-grant: `gnt` is 0 after the same edge. The requester pattern after reset is arbitrated from `ptr`=0.
- Request to grant latency is 1 cycle:
  - `req[i]` sampled high in IDLE at edge n gives `gnt[i]`=1 after edge n.
- Release to grant-drop latency is 1 cycle:
  - `rel` high at edge n gives `gnt`=0 after edge n.
- Minimum handover gap: exactly 1 IDLE cycle between consecutive grants, even with requests pending.
- Continuous requests from all 16 requesters: each is served in order i, i+1, …. Worst-case wait under `ARB_TIMEOUT_EN` is 15·(`MAX_HOLD`+1) cycles.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined**:
  - An 8-bit hold counter clears on GRANT entry and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD`−1, and at least one other `req` bit is set, and no release occurs that cycle, then GRANT exits to IDLE and `tmo` pulses for 1 cycle together with the exit.
  - With no other requester pending, the counter saturates and the owner keeps the grant.
- **Undefined**: no counter is built. Grants last until release or withdrawal. `tmo` is tied to 0.

## Test plan
- Reset, then `req`=0x0001 → after 1 edge `gnt`=0x0001, `sel`=0, `busy`=1. Pulse `rel` → `gnt`=0 next cycle and `ptr`=1.
- `req`=0xFFFF held, `rel` pulsed on each GRANT cycle → grant order 0,1,…,15,0 with one zero-`gnt` cycle between each. `sel` encoding checked against the decoder (grant 9 ⇒ s0..s3 = 1,0,0,1).
- Wrap: grant 15 and release it, then `req`=0x8001 → the next grant goes to 0, not 15.
- Owner withdrawal: grant 5, drop `req[5]` with `rel`=0 → `gnt`=0 next cycle. With `req`=0x0060, the next grant is 6.
- `ARB_TIMEOUT_EN`, `MAX_HOLD`=4, `req`=0x0003 held, no `rel` → `gnt[0]` for 4 cycles, `tmo` pulse, 1 idle cycle, then `gnt[1]`. With `req`=0x0001 alone, the grant is held indefinitely and `tmo` stays 0.
- Assert `rst` mid-grant of requester 7 → `gnt`=0 and `ptr`=0 after the edge. With `req`=0x0081 after reset, the grant goes to 0.
